// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 4-digit BCD converter (double-dabble, one bit per clock).
// Optional build macro BIN2BCD_SATURATE_EN clamps overflowing results to 9999.
module bin2bcd_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin,
    output logic [15:0] bcd,
    output logic        overflow,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t      state_q;
    logic [35:0] work_q;
    logic [35:0] work_d;
    logic [35:0] corr;
    logic [4:0]  cnt_q;
    logic [15:0] bcd_q;
    logic [15:0] bcd_d;
    logic        ovf_q;
    logic        ovf_d;
    logic        busy_q;
    logic        done_q;

    // Add-3 correction on each of the five BCD nibbles, then shift left.
    always_comb begin
        corr = work_q;
        for (int k = 0; k < 5; k++) begin
            if (corr[16+4*k +: 4] >= 4'd5) begin
                corr[16+4*k +: 4] = corr[16+4*k +: 4] + 4'd3;
            end
        end
        work_d = {corr[34:0], 1'b0};
        ovf_d  = (work_d[35:32] != 4'd0);
`ifdef BIN2BCD_SATURATE_EN
        bcd_d  = ovf_d ? 16'h9999 : work_d[31:16];
`else
        bcd_d  = work_d[31:16];
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        work_q  <= {20'b0, bin};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd15) begin
                        bcd_q   <= bcd_d;
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bcd      = bcd_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against an arithmetic decimal model.
// Honours BIN2BCD_SATURATE_EN so either build can be checked.
module tb_bin2bcd_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] bin;
    logic [15:0] bcd;
    logic        overflow;
    logic        busy;
    logic        done;

    int checks = 0;
    int passes = 0;
    logic [15:0] last_bcd = 16'h0000;
    logic        last_ovf = 1'b0;

    bin2bcd_seq dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .bcd      (bcd),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Decimal reference: returns {overflow, bcd}.
    function automatic logic [16:0] ref_bcd(input int v);
        int m;
        logic o;
        logic [15:0] r;
        o = (v > 9999);
        m = v % 10000;
`ifdef BIN2BCD_SATURATE_EN
        if (o) m = 9999;
`endif
        r[15:12] = 4'((m / 1000) % 10);
        r[11:8]  = 4'((m / 100) % 10);
        r[7:4]   = 4'((m / 10) % 10);
        r[3:0]   = 4'(m % 10);
        return {o, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One conversion; optionally pulses a stray start with bin=7 before edge ign_at.
    task automatic conv(input logic [15:0] v, input int ign_at);
        logic [16:0] e;
        e = ref_bcd(int'(v));
        @(negedge clock);
        start = 1'b1;
        bin   = v;
        @(posedge clock);
        #1;
        start = 1'b0;
        bin   = 16'($urandom);
        check("e0_busy", 32'(busy), 32'd1);
        check("e0_done", 32'(done), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            if (i == ign_at) begin
                start = 1'b1;
                bin   = 16'd7;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            if (i < 16) begin
                check("mid_busy", 32'(busy), 32'd1);
                check("mid_done", 32'(done), 32'd0);
                check("mid_bcd_hold", 32'(bcd), 32'(last_bcd));
            end
        end
        check("e16_done", 32'(done), 32'd1);
        check("e16_busy", 32'(busy), 32'd0);
        check("e16_bcd", 32'(bcd), 32'(e[15:0]));
        check("e16_ovf", 32'(overflow), 32'(e[16]));
        last_bcd = e[15:0];
        last_ovf = e[16];
    endtask

    initial begin
        int acc;
        logic [15:0] base;
        logic [15:0] cap;
        logic [16:0] e;

        reset = 1'b1;
        start = 1'b0;
        bin   = 16'd0;
        #1;
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        conv(16'd0, -1);
        conv(16'd1234, -1);
        conv(16'd9999, -1);
        conv(16'd65535, -1);
        conv(16'd10000, -1);

        // Stray start mid-conversion must not queue a second result.
        conv(16'd42, 5);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check("ign_no_done", 32'(done), 32'd0);
            check("ign_idle", 32'(busy), 32'd0);
            check("ign_bcd", 32'(bcd), 32'h0042);
        end

        for (int i = 0; i < 6; i++) begin
            conv(16'($urandom_range(0, 65535)), -1);
        end

        // Reset aborts a conversion at E8.
        conv(16'd321, -1);
        @(negedge clock);
        start = 1'b1;
        bin   = 16'd8888;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            check("abort_no_done", 32'(done), 32'd0);
        end
        last_bcd = 16'h0000;
        last_ovf = 1'b0;
        conv(16'd8888, -1);

        // Start held high with bin incrementing: accept every 17 cycles.
        base = 16'($urandom_range(0, 60000));
        acc  = 0;
        cap  = base;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clock);
            start = 1'b1;
            bin   = base + 16'(cyc);
            if (cyc == acc + 17) begin
                acc = cyc;
                cap = bin;
            end
            @(posedge clock);
            #1;
            if (cyc == acc + 16) begin
                e = ref_bcd(int'(cap));
                check("hold_done", 32'(done), 32'd1);
                check("hold_bcd", 32'(bcd), 32'(e[15:0]));
                check("hold_ovf", 32'(overflow), 32'(e[16]));
                last_bcd = e[15:0];
                last_ovf = e[16];
            end else begin
                check("hold_no_done", 32'(done), 32'd0);
                check("hold_busy", 32'(busy), 32'd1);
                check("hold_stable", 32'(bcd), 32'(last_bcd));
            end
        end
        start = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
